// File: rtl/pa_pkg.sv
// Shared types and default geometry for the processor-array operand path.
// Used by pa_top and by the operand feeder.
package pa_pkg;

  localparam int DEF_SIZE_MAT   = 16;
  localparam int DEF_WIDTH_DATA = 16;
  localparam int DEF_DEPTH      = 64;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // A bank may accept loader traffic only before it has been committed.
  function automatic logic bank_free(bank_state_t s);
    return (s == EMPTY) || (s == FILLING);
  endfunction

  function automatic logic bank_has_data(bank_state_t s);
    return (s == FULL) || (s == DRAINING);
  endfunction

endpackage

// File: rtl/pa_operand_feeder_if.sv
// Loader and array-side handshake of the operand feeder, bundled as one port.
// The master modport is the host/array side, the slave modport is the feeder.
interface pa_operand_feeder_if
  import pa_pkg::*;
#(
  parameter int SIZE_MAT   = DEF_SIZE_MAT,
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int DEPTH      = DEF_DEPTH
) ();

  localparam int WIDTH_ADDR = $clog2(DEPTH);
  localparam int WORD_W     = SIZE_MAT * WIDTH_DATA;

  logic                  wr_en_i;
  logic                  wr_sel_i;
  logic [WIDTH_ADDR-1:0] wr_addr_i;
  logic [WORD_W-1:0]     wr_data_i;
  logic                  load_done_i;
  logic                  load_rdy_o;
  logic                  data_rdy_o;
  logic                  read_en_i;
  logic [WORD_W-1:0]     v_bus_o;
  logic [WORD_W-1:0]     h_bus_o;
  logic                  drain_done_o;
  logic                  err_ovf_o;
  logic                  err_udf_o;
  logic                  err_clr_i;

  modport master (
    output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, load_done_i,
    output read_en_i, err_clr_i,
    input  load_rdy_o, data_rdy_o, v_bus_o, h_bus_o, drain_done_o,
    input  err_ovf_o, err_udf_o
  );

  modport slave (
    input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, load_done_i,
    input  read_en_i, err_clr_i,
    output load_rdy_o, data_rdy_o, v_bus_o, h_bus_o, drain_done_o,
    output err_ovf_o, err_udf_o
  );

endinterface

// File: rtl/pa_feed_bank.sv
// One operand bank: vertical and horizontal word memories plus the bank's
// EMPTY/FILLING/FULL/DRAINING state. All strobes arrive already qualified.
module pa_feed_bank
  import pa_pkg::*;
#(
  parameter int WORD_W     = DEF_SIZE_MAT * DEF_WIDTH_DATA,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH_ADDR = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [WIDTH_ADDR-1:0] wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  commit,
  input  logic                  pop,
  input  logic                  free,
  input  logic [WIDTH_ADDR-1:0] rd_addr,
  output bank_state_t           state,
  output logic [WORD_W-1:0]     v_rd,
  output logic [WORD_W-1:0]     h_rd
);

  logic [WORD_W-1:0] mem_v [DEPTH];
  logic [WORD_W-1:0] mem_h [DEPTH];
  bank_state_t       state_d;

  // NOTE: the memories sit outside the reset domain on purpose; clearing them
  // would force flops instead of RAM, and a block is only ever read after it
  // has been (re)committed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) mem_h[wr_addr] <= wr_data;
      else        mem_v[wr_addr] <= wr_data;
    end
  end

  assign v_rd = mem_v[rd_addr];
  assign h_rd = mem_h[rd_addr];

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      EMPTY: begin
        if (commit)     state_d = FULL;
        else if (wr_en) state_d = FILLING;
      end
      FILLING: begin
        if (commit) state_d = FULL;
      end
      FULL: begin
        // A one-word block frees on its first pop.
        if (free)     state_d = EMPTY;
        else if (pop) state_d = DRAINING;
      end
      DRAINING: begin
        if (free) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/pa_operand_feeder.sv
// Double-buffered operand source for the processor array: a loader fills one
// bank while the array pops word-pairs from the other.
module pa_operand_feeder
  import pa_pkg::*;
#(
  parameter int SIZE_MAT   = DEF_SIZE_MAT,
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  pa_operand_feeder_if.slave  bus
);

  localparam int WIDTH_ADDR = $clog2(DEPTH);
  localparam int WORD_W     = SIZE_MAT * WIDTH_DATA;

  bank_state_t           bank_state [2];
  logic [WORD_W-1:0]     v_rd [2];
  logic [WORD_W-1:0]     h_rd [2];

  logic                  wr_bank;
  logic                  rd_bank;
  logic [WIDTH_ADDR-1:0] rd_ptr;
  logic [WORD_W-1:0]     v_bus;
  logic [WORD_W-1:0]     h_bus;
  logic                  drain_done;
  logic                  err_ovf;
  logic                  err_udf;

  logic load_rdy, data_rdy;
  logic wr_ok, commit_ok, pop_ok, last_pop;
  logic ovf_evt, udf_evt;

  // Both ready flags decode registered state only.
  assign load_rdy  = bank_free(bank_state[wr_bank]);
  assign data_rdy  = bank_has_data(bank_state[rd_bank]);

  assign wr_ok     = bus.wr_en_i     && load_rdy;
  assign commit_ok = bus.load_done_i && load_rdy;
  assign pop_ok    = bus.read_en_i   && data_rdy;
  assign last_pop  = pop_ok && (rd_ptr == WIDTH_ADDR'(DEPTH - 1));
  assign ovf_evt   = (bus.wr_en_i || bus.load_done_i) && !load_rdy;
  assign udf_evt   = bus.read_en_i && !data_rdy;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pa_feed_bank #(
      .WORD_W     (WORD_W),
      .DEPTH      (DEPTH),
      .WIDTH_ADDR (WIDTH_ADDR)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok     && (wr_bank == 1'(b))),
      .wr_sel  (bus.wr_sel_i),
      .wr_addr (bus.wr_addr_i),
      .wr_data (bus.wr_data_i),
      .commit  (commit_ok && (wr_bank == 1'(b))),
      .pop     (pop_ok    && (rd_bank == 1'(b))),
      .free    (last_pop  && (rd_bank == 1'(b))),
      .rd_addr (rd_ptr),
      .state   (bank_state[b]),
      .v_rd    (v_rd[b]),
      .h_rd    (h_rd[b])
    );
  end

  // Commit and final pop touch different banks, so both apply in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_ptr     <= '0;
      v_bus      <= '0;
      h_bus      <= '0;
      drain_done <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      if (commit_ok) wr_bank <= ~wr_bank;
      if (pop_ok) begin
        v_bus  <= v_rd[rd_bank];
        h_bus  <= h_rd[rd_bank];
        rd_ptr <= rd_ptr + 1'b1;
        if (last_pop) begin
          rd_bank    <= ~rd_bank;
          drain_done <= 1'b1;
        end
      end
      // A fresh error outranks a clear in the same cycle.
      if (ovf_evt)            err_ovf <= 1'b1;
      else if (bus.err_clr_i) err_ovf <= 1'b0;
      if (udf_evt)            err_udf <= 1'b1;
      else if (bus.err_clr_i) err_udf <= 1'b0;
    end
  end

  assign bus.load_rdy_o   = load_rdy;
  assign bus.data_rdy_o   = data_rdy;
  assign bus.v_bus_o      = v_bus;
  assign bus.h_bus_o      = h_bus;
  assign bus.drain_done_o = drain_done;
  assign bus.err_ovf_o    = err_ovf;
  assign bus.err_udf_o    = err_udf;

endmodule

// File: tb/tb_pa_operand_feeder.sv
// Bench for pa_operand_feeder: directed scenarios plus random traffic, every
// cycle compared against a queue-of-committed-blocks reference model.
module tb_pa_operand_feeder;

  localparam int SIZE_MAT   = 16;
  localparam int WIDTH_DATA = 16;
  localparam int DEPTH      = 64;
  localparam int WA         = $clog2(DEPTH);
  localparam int W          = SIZE_MAT * WIDTH_DATA;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pa_operand_feeder_if #(
    .SIZE_MAT(SIZE_MAT), .WIDTH_DATA(WIDTH_DATA), .DEPTH(DEPTH)
  ) bus ();

  pa_operand_feeder #(
    .SIZE_MAT(SIZE_MAT), .WIDTH_DATA(WIDTH_DATA), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: block storage per bank and a FIFO of committed banks.
  logic [W-1:0] m_mem [2][2][DEPTH];
  int           m_q[$];
  logic         m_wb;
  int           m_ptr;
  logic [W-1:0] m_v, m_h;
  logic         m_dd, m_ovf, m_udf;

  task automatic model_reset();
    m_q.delete();
    m_wb  = 1'b0;
    m_ptr = 0;
    m_v   = '0;
    m_h   = '0;
    m_dd  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_update();
    bit lr, dr;
    if (rst) begin
      model_reset();
      return;
    end
    lr = (m_q.size() < 2);
    dr = (m_q.size() > 0);
    if ((bus.wr_en_i || bus.load_done_i) && !lr) m_ovf = 1'b1;
    else if (bus.err_clr_i)                      m_ovf = 1'b0;
    if (bus.read_en_i && !dr)                    m_udf = 1'b1;
    else if (bus.err_clr_i)                      m_udf = 1'b0;
    m_dd = 1'b0;
    if (bus.wr_en_i && lr) m_mem[m_wb][bus.wr_sel_i][bus.wr_addr_i] = bus.wr_data_i;
    if (bus.read_en_i && dr) begin
      m_v = m_mem[m_q[0]][0][m_ptr];
      m_h = m_mem[m_q[0]][1][m_ptr];
      m_ptr++;
      if (m_ptr == DEPTH) begin
        void'(m_q.pop_front());
        m_ptr = 0;
        m_dd  = 1'b1;
      end
    end
    if (bus.load_done_i && lr) begin
      m_q.push_back(int'(m_wb));
      m_wb = ~m_wb;
    end
  endtask

  task automatic compare_outputs();
    check("load_rdy",   W'(bus.load_rdy_o),   W'(m_q.size() < 2));
    check("data_rdy",   W'(bus.data_rdy_o),   W'(m_q.size() > 0));
    check("v_bus",      bus.v_bus_o,          m_v);
    check("h_bus",      bus.h_bus_o,          m_h);
    check("drain_done", W'(bus.drain_done_o), W'(m_dd));
    check("err_ovf",    W'(bus.err_ovf_o),    W'(m_ovf));
    check("err_udf",    W'(bus.err_udf_o),    W'(m_udf));
  endtask

  task automatic idle();
    bus.wr_en_i     = 1'b0;
    bus.wr_sel_i    = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.load_done_i = 1'b0;
    bus.read_en_i   = 1'b0;
    bus.err_clr_i   = 1'b0;
  endtask

  // One clock: model sees the same inputs the DUT samples, then outputs are
  // compared 1 time unit after the edge and inputs return to idle.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
    idle();
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [W-1:0] pattern_word(input int k, input int base);
    logic [W-1:0] w;
    for (int i = 0; i < SIZE_MAT; i++) w[WIDTH_DATA*i +: WIDTH_DATA] = WIDTH_DATA'(base + k * 16 + i);
    return w;
  endfunction

  task automatic write_word(input logic sel, input int addr, input logic [W-1:0] data);
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = sel;
    bus.wr_addr_i = WA'(addr);
    bus.wr_data_i = data;
    tick();
  endtask

  task automatic load_random_block();
    for (int k = 0; k < DEPTH; k++) begin
      write_word(1'b0, k, rand_word());
      write_word(1'b1, k, rand_word());
    end
  endtask

  task automatic commit();
    bus.load_done_i = 1'b1;
    tick();
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) begin
      bus.read_en_i = 1'b1;
      tick();
    end
  endtask

  // Reset is raised between edges and checked before any clock arrives.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < DEPTH; a++) m_mem[b][s][a] = '0;
    #1;
    compare_outputs();
    tick();
    tick();
    rst = 1'b0;

    // Underflow with nothing committed, clear, then set-beats-clear.
    pops(2);
    bus.err_clr_i = 1'b1;
    tick();
    bus.read_en_i = 1'b1;
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b1;
    tick();

    // Pattern block into B0, commit, full-rate drain.
    for (int k = 0; k < DEPTH; k++) begin
      write_word(1'b0, k, pattern_word(k, 0));
      write_word(1'b1, k, pattern_word(k, 'h100));
    end
    commit();
    pops(DEPTH);
    tick();

    // Fill both banks, overflow with a third write and a third commit.
    async_reset();
    load_random_block();
    commit();
    load_random_block();
    commit();
    write_word(1'b0, 0, rand_word());
    bus.load_done_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b1;
    tick();
    pops(2 * DEPTH);
    tick();

    // Commit of the second bank coincides with the final pop of the first.
    load_random_block();
    commit();
    load_random_block();
    pops(DEPTH - 1);
    bus.read_en_i   = 1'b1;
    bus.load_done_i = 1'b1;
    tick();
    pops(DEPTH);

    // Reset in the middle of a drain, then a fresh block from word 0.
    load_random_block();
    commit();
    pops(20);
    async_reset();
    load_random_block();
    commit();
    pops(DEPTH);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      bus.wr_en_i     = ($urandom_range(0, 1) == 1);
      bus.wr_sel_i    = 1'($urandom_range(0, 1));
      bus.wr_addr_i   = WA'($urandom());
      bus.wr_data_i   = rand_word();
      bus.load_done_i = ($urandom_range(0, 39) == 0);
      bus.read_en_i   = ($urandom_range(0, 2) != 0);
      bus.err_clr_i   = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
